// File: rtl/axi4_mgr_pkg.sv
// Shared types for the AXI4 burst manager: burst/response encodings, FSM states
// and the beat-count-to-AxLEN helper.
package axi4_mgr_pkg;

    typedef enum logic [1:0] {
        BurstFixed = 2'b00,
        BurstIncr  = 2'b01,
        BurstWrap  = 2'b10
    } axi_burst_e;

    typedef enum logic [1:0] {
        RespOkay   = 2'b00,
        RespExokay = 2'b01,
        RespSlverr = 2'b10,
        RespDecerr = 2'b11
    } axi_resp_e;

    typedef enum logic [1:0] {
        WrIdle,
        WrAw,
        WrW,
        WrB
    } wr_state_t;

    typedef enum logic [1:0] {
        RdIdle,
        RdAr,
        RdR
    } rd_state_t;

    localparam int unsigned MaxBurstBeats = 256;

    // AxLEN for a request of 'count' words, capped at the largest INCR burst.
    function automatic logic [7:0] burst_len(input int unsigned count);
        if (count >= MaxBurstBeats) begin
            return 8'hFF;
        end
        return 8'(count - 1);
    endfunction

endpackage

// File: rtl/axi4_bus_if.sv
// AXI4 bus bundle with manager and subordinate views.
interface axi4_bus_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned USER_WIDTH = 1
);
    localparam int unsigned StrbWidth = DATA_WIDTH / 8;

    logic [ID_WIDTH-1:0]   aw_id;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]            aw_len;
    logic [2:0]            aw_size;
    logic [1:0]            aw_burst;
    logic                  aw_lock;
    logic [3:0]            aw_cache;
    logic [2:0]            aw_prot;
    logic [3:0]            aw_qos;
    logic [3:0]            aw_region;
    logic [5:0]            aw_atop;
    logic [USER_WIDTH-1:0] aw_user;
    logic                  aw_valid;
    logic                  aw_ready;

    logic [DATA_WIDTH-1:0] w_data;
    logic [StrbWidth-1:0]  w_strb;
    logic                  w_last;
    logic [USER_WIDTH-1:0] w_user;
    logic                  w_valid;
    logic                  w_ready;

    logic [ID_WIDTH-1:0]   b_id;
    logic [1:0]            b_resp;
    logic [USER_WIDTH-1:0] b_user;
    logic                  b_valid;
    logic                  b_ready;

    logic [ID_WIDTH-1:0]   ar_id;
    logic [ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]            ar_len;
    logic [2:0]            ar_size;
    logic [1:0]            ar_burst;
    logic                  ar_lock;
    logic [3:0]            ar_cache;
    logic [2:0]            ar_prot;
    logic [3:0]            ar_qos;
    logic [3:0]            ar_region;
    logic [USER_WIDTH-1:0] ar_user;
    logic                  ar_valid;
    logic                  ar_ready;

    logic [ID_WIDTH-1:0]   r_id;
    logic [DATA_WIDTH-1:0] r_data;
    logic [1:0]            r_resp;
    logic                  r_last;
    logic [USER_WIDTH-1:0] r_user;
    logic                  r_valid;
    logic                  r_ready;

    modport manager (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_atop, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport subordinate (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_atop, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );

endinterface

// File: rtl/axi4_burst_mgr.sv
// AXI4 manager moving one INCR burst between local FIFOs and the bus per request.
// Write and read paths are independent FSMs sharing only the clock and reset.
module axi4_burst_mgr
    import axi4_mgr_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH   = 32,
    parameter int unsigned AXI_DATA_WIDTH   = 64,
    parameter int unsigned AXI_XSIZE        = 8,
    parameter int unsigned DATA_COUNT_WIDTH = 10
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [1:0]                  req_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   axi_wr_addr_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   axi_rd_addr_i,
    input  logic                        wr_fifo_gnt_i,
    input  logic                        rd_fifo_req_i,
    input  logic [AXI_DATA_WIDTH-1:0]   wr_fifo_data_i,
    input  logic [DATA_COUNT_WIDTH-1:0] wr_data_count_i,
    input  logic [DATA_COUNT_WIDTH-1:0] rd_data_count_i,
    output logic [1:0]                  busy_o,
    output logic [1:0]                  wr_err_o,
    output logic [1:0]                  rd_err_o,
    output logic                        wr_fifo_req_o,
    output logic                        rd_fifo_gnt_o,
    output logic [AXI_DATA_WIDTH-1:0]   rd_fifo_data_o,
    axi4_bus_if.manager                 axi_mgr_if
);

    localparam logic [2:0] AxSize = 3'($clog2(AXI_XSIZE));

    wr_state_t                 wr_state_q, wr_state_d;
    logic [AXI_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]                wr_len_q, wr_len_d;
    logic [7:0]                wr_beat_q, wr_beat_d;
    logic [1:0]                wr_err_q, wr_err_d;

    rd_state_t                 rd_state_q, rd_state_d;
    logic [AXI_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [7:0]                rd_len_q, rd_len_d;
    logic [1:0]                rd_err_q, rd_err_d;

    logic                      w_fire;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_state_q <= WrIdle;
            wr_addr_q  <= '0;
            wr_len_q   <= '0;
            wr_beat_q  <= '0;
            wr_err_q   <= RespOkay;
            rd_state_q <= RdIdle;
            rd_addr_q  <= '0;
            rd_len_q   <= '0;
            rd_err_q   <= RespOkay;
        end else begin
            wr_state_q <= wr_state_d;
            wr_addr_q  <= wr_addr_d;
            wr_len_q   <= wr_len_d;
            wr_beat_q  <= wr_beat_d;
            wr_err_q   <= wr_err_d;
            rd_state_q <= rd_state_d;
            rd_addr_q  <= rd_addr_d;
            rd_len_q   <= rd_len_d;
            rd_err_q   <= rd_err_d;
        end
    end

    // Write path: one AW, then len+1 W beats popped straight from the FIFO head, then B.
    always_comb begin
        wr_state_d          = wr_state_q;
        wr_addr_d           = wr_addr_q;
        wr_len_d            = wr_len_q;
        wr_beat_d           = wr_beat_q;
        wr_err_d            = wr_err_q;
        axi_mgr_if.aw_valid = 1'b0;
        axi_mgr_if.w_valid  = 1'b0;
        axi_mgr_if.w_last   = 1'b0;
        axi_mgr_if.b_ready  = 1'b0;
        w_fire              = 1'b0;
        wr_fifo_req_o       = 1'b0;

        unique case (wr_state_q)
            WrIdle: begin
                if (req_i[0] && (wr_data_count_i != '0)) begin
                    wr_addr_d  = axi_wr_addr_i;
                    wr_len_d   = burst_len(32'(wr_data_count_i));
                    wr_err_d   = RespOkay;
                    wr_state_d = WrAw;
                end
            end
            WrAw: begin
                axi_mgr_if.aw_valid = 1'b1;
                if (axi_mgr_if.aw_ready) begin
                    wr_beat_d  = '0;
                    wr_state_d = WrW;
                end
            end
            WrW: begin
                axi_mgr_if.w_valid = wr_fifo_gnt_i;
                axi_mgr_if.w_last  = (wr_beat_q == wr_len_q);
                w_fire             = wr_fifo_gnt_i && axi_mgr_if.w_ready;
                wr_fifo_req_o      = w_fire;
                if (w_fire) begin
                    if (wr_beat_q == wr_len_q) begin
                        wr_state_d = WrB;
                    end else begin
                        wr_beat_d = wr_beat_q + 8'd1;
                    end
                end
            end
            WrB: begin
                axi_mgr_if.b_ready = 1'b1;
                if (axi_mgr_if.b_valid) begin
                    wr_err_d   = axi_mgr_if.b_resp;
                    wr_state_d = WrIdle;
                end
            end
            default: wr_state_d = WrIdle;
        endcase
    end

    // Read path: r_ready follows FIFO space so every accepted beat is pushed.
    always_comb begin
        rd_state_d          = rd_state_q;
        rd_addr_d           = rd_addr_q;
        rd_len_d            = rd_len_q;
        rd_err_d            = rd_err_q;
        axi_mgr_if.ar_valid = 1'b0;
        axi_mgr_if.r_ready  = 1'b0;
        rd_fifo_gnt_o       = 1'b0;

        unique case (rd_state_q)
            RdIdle: begin
                if (req_i[1] && (rd_data_count_i != '0)) begin
                    rd_addr_d  = axi_rd_addr_i;
                    rd_len_d   = burst_len(32'(rd_data_count_i));
                    rd_err_d   = RespOkay;
                    rd_state_d = RdAr;
                end
            end
            RdAr: begin
                axi_mgr_if.ar_valid = 1'b1;
                if (axi_mgr_if.ar_ready) begin
                    rd_state_d = RdR;
                end
            end
            RdR: begin
                axi_mgr_if.r_ready = rd_fifo_req_i;
                if (axi_mgr_if.r_valid && rd_fifo_req_i) begin
                    rd_fifo_gnt_o = 1'b1;
                    if (axi_mgr_if.r_resp > rd_err_q) begin
                        rd_err_d = axi_mgr_if.r_resp;
                    end
                    if (axi_mgr_if.r_last) begin
                        rd_state_d = RdIdle;
                    end
                end
            end
            default: rd_state_d = RdIdle;
        endcase
    end

    assign axi_mgr_if.aw_id     = '0;
    assign axi_mgr_if.aw_addr   = wr_addr_q;
    assign axi_mgr_if.aw_len    = wr_len_q;
    assign axi_mgr_if.aw_size   = AxSize;
    assign axi_mgr_if.aw_burst  = BurstIncr;
    assign axi_mgr_if.aw_lock   = 1'b0;
    assign axi_mgr_if.aw_cache  = '0;
    assign axi_mgr_if.aw_prot   = '0;
    assign axi_mgr_if.aw_qos    = '0;
    assign axi_mgr_if.aw_region = '0;
    assign axi_mgr_if.aw_atop   = '0;
    assign axi_mgr_if.aw_user   = '0;

    assign axi_mgr_if.w_data    = wr_fifo_data_i;
    assign axi_mgr_if.w_strb    = '1;
    assign axi_mgr_if.w_user    = '0;

    assign axi_mgr_if.ar_id     = '0;
    assign axi_mgr_if.ar_addr   = rd_addr_q;
    assign axi_mgr_if.ar_len    = rd_len_q;
    assign axi_mgr_if.ar_size   = AxSize;
    assign axi_mgr_if.ar_burst  = BurstIncr;
    assign axi_mgr_if.ar_lock   = 1'b0;
    assign axi_mgr_if.ar_cache  = '0;
    assign axi_mgr_if.ar_prot   = '0;
    assign axi_mgr_if.ar_qos    = '0;
    assign axi_mgr_if.ar_region = '0;
    assign axi_mgr_if.ar_user   = '0;

    assign rd_fifo_data_o = axi_mgr_if.r_data;
    assign busy_o         = {rd_state_q != RdIdle, wr_state_q != WrIdle};
    assign wr_err_o       = wr_err_q;
    assign rd_err_o       = rd_err_q;

    // IDs and user bits are fixed at zero, so the returned copies carry no information.
    logic unused_rsp_fields;
    assign unused_rsp_fields = ^{axi_mgr_if.b_id, axi_mgr_if.b_user,
                                 axi_mgr_if.r_id, axi_mgr_if.r_user};

endmodule

// File: tb/tb_axi4_burst_mgr.sv
// Randomized bench for axi4_burst_mgr: a reactive subordinate plus FIFO models,
// checked against burst-level expectations derived from each request.
module tb_axi4_burst_mgr;
    import axi4_mgr_pkg::*;

    localparam int AW  = 32;
    localparam int DW  = 64;
    localparam int DCW = 10;

    logic           clk = 1'b0;
    logic           rst_i = 1'b1;
    logic [1:0]     req;
    logic [AW-1:0]  wr_addr, rd_addr;
    logic           wr_fifo_gnt, rd_fifo_req;
    logic [DW-1:0]  wr_fifo_data;
    logic [DCW-1:0] wr_count, rd_count;
    logic [1:0]     busy, wr_err, rd_err;
    logic           wr_fifo_req, rd_fifo_gnt;
    logic [DW-1:0]  rd_fifo_data;

    axi4_bus_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi4_burst_mgr #(
        .AXI_ADDR_WIDTH  (AW),
        .AXI_DATA_WIDTH  (DW),
        .AXI_XSIZE       (8),
        .DATA_COUNT_WIDTH(DCW)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .req_i          (req),
        .axi_wr_addr_i  (wr_addr),
        .axi_rd_addr_i  (rd_addr),
        .wr_fifo_gnt_i  (wr_fifo_gnt),
        .rd_fifo_req_i  (rd_fifo_req),
        .wr_fifo_data_i (wr_fifo_data),
        .wr_data_count_i(wr_count),
        .rd_data_count_i(rd_count),
        .busy_o         (busy),
        .wr_err_o       (wr_err),
        .rd_err_o       (rd_err),
        .wr_fifo_req_o  (wr_fifo_req),
        .rd_fifo_gnt_o  (rd_fifo_gnt),
        .rd_fifo_data_o (rd_fifo_data),
        .axi_mgr_if     (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } ax_t;

    ax_t         aw_log[$], ar_log[$];
    logic [63:0] w_log[$], rsent_log[$], push_log[$], wfifo[$], exp_w[$];
    bit          wlast_log[$];
    int          r_lens[$];
    int          pop_cnt, b_cnt, stall_viol, b_pend, r_beat;
    logic [1:0]  last_bresp, rresp_max, bresp_force;
    bit          bresp_force_en;
    bit          f_pop, f_b, f_r;

    int          exp_wn, exp_wlen, exp_rlen;
    logic [31:0] exp_waddr, exp_raddr;

    // Subordinate + FIFO model: drive at posedge+1, sample handshakes at negedge.
    initial begin : sub_model
        bus.aw_ready = 1'b0; bus.w_ready = 1'b0; bus.ar_ready = 1'b0;
        bus.b_id = '0; bus.b_resp = '0; bus.b_user = '0; bus.b_valid = 1'b0;
        bus.r_id = '0; bus.r_data = '0; bus.r_resp = '0; bus.r_last = 1'b0;
        bus.r_user = '0; bus.r_valid = 1'b0;
        wr_fifo_gnt = 1'b0; wr_fifo_data = '0; wr_count = '0; rd_fifo_req = 1'b0;
        b_pend = 0; r_beat = 0; stall_viol = 0; f_pop = 0; f_b = 0; f_r = 0;
        forever begin
            @(posedge clk); #1;
            if (rst_i) begin
                b_pend = 0; r_beat = 0; r_lens.delete();
                bus.b_valid = 1'b0; bus.r_valid = 1'b0; bus.r_last = 1'b0;
                bus.aw_ready = 1'b0; bus.w_ready = 1'b0; bus.ar_ready = 1'b0;
            end else begin
                if (f_pop && wfifo.size() > 0) void'(wfifo.pop_front());
                if (f_b) bus.b_valid = 1'b0;
                if (f_r) begin
                    bus.r_valid = 1'b0;
                    if (bus.r_last) begin
                        void'(r_lens.pop_front());
                        r_beat = 0;
                    end else begin
                        r_beat++;
                    end
                end
                if (!bus.b_valid && b_pend > 0 && $urandom_range(0, 2) == 0) begin
                    bus.b_valid = 1'b1;
                    bus.b_resp  = bresp_force_en ? bresp_force :
                                  (($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00);
                    b_pend--;
                end
                if (!bus.r_valid && r_lens.size() > 0 && $urandom_range(0, 3) != 0) begin
                    bus.r_valid = 1'b1;
                    bus.r_data  = {$urandom, $urandom};
                    bus.r_resp  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
                    bus.r_last  = (r_beat == r_lens[0]);
                end
                bus.aw_ready = ($urandom_range(0, 3) == 0);
                bus.w_ready  = ($urandom_range(0, 2) != 0);
                bus.ar_ready = ($urandom_range(0, 3) == 0);
                rd_fifo_req  = ($urandom_range(0, 3) != 0);
            end
            wr_fifo_gnt  = (wfifo.size() > 0);
            wr_fifo_data = (wfifo.size() > 0) ? wfifo[0] : 64'd0;
            wr_count     = DCW'(wfifo.size());
            @(negedge clk);
            f_pop = 0; f_b = 0; f_r = 0;
            if (!rst_i) begin
                if (bus.aw_valid && bus.aw_ready)
                    aw_log.push_back({bus.aw_addr, bus.aw_len, bus.aw_size, bus.aw_burst});
                if (bus.w_valid && bus.w_ready) begin
                    w_log.push_back(bus.w_data);
                    wlast_log.push_back(bus.w_last);
                    if (bus.w_last) b_pend++;
                end
                if (wr_fifo_req) begin
                    f_pop = 1;
                    pop_cnt++;
                end
                if (bus.b_valid && bus.b_ready) begin
                    f_b = 1;
                    b_cnt++;
                    last_bresp = bus.b_resp;
                end
                if (bus.ar_valid && bus.ar_ready) begin
                    ar_log.push_back({bus.ar_addr, bus.ar_len, bus.ar_size, bus.ar_burst});
                    r_lens.push_back(int'(bus.ar_len));
                end
                if (bus.r_valid && bus.r_ready) begin
                    f_r = 1;
                    rsent_log.push_back(bus.r_data);
                    if (bus.r_resp > rresp_max) rresp_max = bus.r_resp;
                end
                if (rd_fifo_gnt) push_log.push_back(rd_fifo_data);
                if (rd_fifo_gnt && !rd_fifo_req) stall_viol++;
            end
        end
    end

    task automatic prep_write(input logic [31:0] addr, input int n, input bit seq);
        logic [63:0] w;
        aw_log.delete(); w_log.delete(); wlast_log.delete(); exp_w.delete();
        pop_cnt = 0; b_cnt = 0; last_bresp = 2'b00;
        wfifo.delete();
        for (int i = 0; i < n; i++) begin
            w = seq ? 64'(i) : {$urandom, $urandom};
            wfifo.push_back(w);
            exp_w.push_back(w);
        end
        exp_wn    = n;
        exp_wlen  = (n > 256) ? 255 : n - 1;
        exp_waddr = addr;
        wr_addr   = addr;
    endtask

    task automatic prep_read(input logic [31:0] addr, input int n);
        ar_log.delete(); rsent_log.delete(); push_log.delete();
        rresp_max = 2'b00;
        exp_rlen  = (n > 256) ? 255 : n - 1;
        exp_raddr = addr;
        rd_addr   = addr;
        rd_count  = DCW'(n);
    endtask

    task automatic issue(input logic [1:0] r);
        @(posedge clk); #2;
        req = r;
        @(posedge clk); #2;
        req = 2'b00;
    endtask

    task automatic wait_idle(input logic [1:0] mask, input string tag);
        int cyc = 0;
        while ((busy & mask) != 2'b00 && cyc < 5000) begin
            @(posedge clk); #2;
            cyc++;
        end
        check_eq(tag, 64'((busy & mask) == 2'b00), 64'd1);
    endtask

    task automatic check_write();
        int nb = exp_wlen + 1;
        int nlast = 0;
        check_eq("wr_aw_count", 64'(aw_log.size()), 64'd1);
        if (aw_log.size() > 0) begin
            check_eq("wr_aw_addr", 64'(aw_log[0].addr), 64'(exp_waddr));
            check_eq("wr_aw_len", 64'(aw_log[0].len), 64'(exp_wlen));
            check_eq("wr_aw_size", 64'(aw_log[0].size), 64'd3);
            check_eq("wr_aw_burst", 64'(aw_log[0].burst), 64'd1);
        end
        check_eq("wr_beats", 64'(w_log.size()), 64'(nb));
        for (int i = 0; i < w_log.size() && i < nb; i++) begin
            check_eq($sformatf("wr_data[%0d]", i), w_log[i], exp_w[i]);
            if (wlast_log[i]) nlast++;
        end
        check_eq("wr_last_count", 64'(nlast), 64'd1);
        if (w_log.size() == nb) check_eq("wr_last_pos", 64'(wlast_log[nb-1]), 64'd1);
        check_eq("wr_pops", 64'(pop_cnt), 64'(nb));
        check_eq("wr_fifo_left", 64'(wfifo.size()), 64'(exp_wn - nb));
        check_eq("wr_b_count", 64'(b_cnt), 64'd1);
        check_eq("wr_err", 64'(wr_err), 64'(last_bresp));
    endtask

    task automatic check_read();
        int nb = exp_rlen + 1;
        check_eq("rd_ar_count", 64'(ar_log.size()), 64'd1);
        if (ar_log.size() > 0) begin
            check_eq("rd_ar_addr", 64'(ar_log[0].addr), 64'(exp_raddr));
            check_eq("rd_ar_len", 64'(ar_log[0].len), 64'(exp_rlen));
            check_eq("rd_ar_size", 64'(ar_log[0].size), 64'd3);
            check_eq("rd_ar_burst", 64'(ar_log[0].burst), 64'd1);
        end
        check_eq("rd_beats", 64'(rsent_log.size()), 64'(nb));
        check_eq("rd_pushes", 64'(push_log.size()), 64'(nb));
        for (int i = 0; i < push_log.size() && i < rsent_log.size(); i++)
            check_eq($sformatf("rd_data[%0d]", i), push_log[i], rsent_log[i]);
        check_eq("rd_err", 64'(rd_err), 64'(rresp_max));
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        int cyc;
        req = 2'b00; wr_addr = '0; rd_addr = '0; rd_count = '0;
        bresp_force_en = 1'b1; bresp_force = 2'b00;
        repeat (3) @(posedge clk);
        #2;
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_wr_err", 64'(wr_err), 64'd0);
        check_eq("rst_rd_err", 64'(rd_err), 64'd0);
        check_eq("rst_valids", 64'({bus.aw_valid, bus.w_valid, bus.ar_valid}), 64'd0);
        check_eq("rst_readys", 64'({bus.b_ready, bus.r_ready}), 64'd0);
        check_eq("rst_fifo_hs", 64'({wr_fifo_req, rd_fifo_gnt}), 64'd0);
        rst_i = 1'b0;

        // Directed single-beat and five-beat writes
        prep_write(32'h5000, 1, 1'b1);
        issue(2'b01);
        wait_idle(2'b01, "w1_done");
        check_write();
        prep_write(32'h5100, 5, 1'b1);
        issue(2'b01);
        wait_idle(2'b01, "w5_done");
        check_write();

        // Random writes including a capped 256-beat burst
        bresp_force_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            n = (k == 4) ? 300 : int'($urandom_range(1, 40));
            prep_write($urandom & 32'hFFFF_FFF8, n, 1'b0);
            issue(2'b01);
            wait_idle(2'b01, "wr_rand_done");
            check_write();
        end

        // Reads: directed count 4, then random
        prep_read(32'h6000, 4);
        issue(2'b10);
        wait_idle(2'b10, "r4_done");
        check_read();
        for (int k = 0; k < 5; k++) begin
            n = (k == 4) ? 270 : int'($urandom_range(1, 40));
            prep_read($urandom & 32'hFFFF_FFF8, n);
            issue(2'b10);
            wait_idle(2'b10, "rd_rand_done");
            check_read();
        end

        // SLVERR is held until the next accepted write clears it
        bresp_force_en = 1'b1; bresp_force = 2'b10;
        prep_write(32'h7000, 3, 1'b0);
        issue(2'b01);
        wait_idle(2'b01, "werr_done");
        check_write();
        repeat (4) @(posedge clk);
        #2;
        check_eq("wr_err_held", 64'(wr_err), 64'd2);
        bresp_force = 2'b00;
        prep_write(32'h7100, 2, 1'b0);
        issue(2'b01);
        check_eq("wr_err_cleared", 64'(wr_err), 64'd0);
        check_eq("wr_busy_after_req", 64'(busy[0]), 64'd1);
        wait_idle(2'b01, "wclr_done");
        check_write();

        // Zero-count requests are ignored
        prep_write(32'h8000, 0, 1'b1);
        prep_read(32'h8100, 0);
        issue(2'b11);
        repeat (5) @(posedge clk);
        #2;
        check_eq("cnt0_busy", 64'(busy), 64'd0);
        check_eq("cnt0_aw", 64'(aw_log.size()), 64'd0);
        check_eq("cnt0_ar", 64'(ar_log.size()), 64'd0);

        // A second request while busy is ignored
        prep_write(32'h7800, 12, 1'b0);
        issue(2'b01);
        wr_addr = 32'h9000;
        repeat (2) @(posedge clk);
        #2;
        issue(2'b01);
        wait_idle(2'b01, "wbusy_done");
        check_write();

        // Simultaneous write and read
        bresp_force_en = 1'b0;
        prep_write(32'hA000, 7, 1'b0);
        prep_read(32'hB000, 9);
        issue(2'b11);
        wait_idle(2'b11, "both_done");
        check_write();
        check_read();

        // Reset in the middle of the W phase
        prep_write(32'hC000, 60, 1'b0);
        issue(2'b01);
        cyc = 0;
        while (w_log.size() < 2 && cyc < 3000) begin
            @(posedge clk); #2;
            cyc++;
        end
        check_eq("rstw_reached_w", 64'(w_log.size() >= 2), 64'd1);
        rst_i = 1'b1;
        @(posedge clk); #2;
        check_eq("rstw_w_valid", 64'(bus.w_valid), 64'd0);
        check_eq("rstw_busy", 64'(busy), 64'd0);
        check_eq("rstw_pop", 64'(wr_fifo_req), 64'd0);
        rst_i = 1'b0;
        wfifo.delete();
        repeat (2) @(posedge clk);
        #2;
        prep_write(32'hD000, 3, 1'b0);
        issue(2'b01);
        wait_idle(2'b01, "post_rst_done");
        check_write();

        check_eq("no_push_on_stall", 64'(stall_viol), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
